// File: rtl/mc_window_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_window_sequencer_if
// Description : Handshake/bus bundle between the window sequencer and its
//               surroundings (s2p stage, window SRAM, calc stage).
//               With MC_SEQ_RD_STALL_EN defined the bundle also carries the
//               read-stall request from the calc stage.
// Revision    : 1.0  initial release
// ============================================================================
interface mc_window_sequencer_if #(
    parameter int ADDR_W = 8
);

    // Control inputs towards the sequencer
    logic              run;
    logic              pix_valid;
`ifdef MC_SEQ_RD_STALL_EN
    logic              rd_stall;
`endif

    // Sequencer outputs
    logic              s2p_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              calc_en;
    logic              pass_done;
    logic              err_drop;

    // Environment side: drives control, observes strobes and addresses
    modport master (
        output run,
        output pix_valid,
`ifdef MC_SEQ_RD_STALL_EN
        output rd_stall,
`endif
        input  s2p_en,
        input  wr_en,
        input  wr_addr,
        input  rd_en,
        input  rd_addr,
        input  calc_en,
        input  pass_done,
        input  err_drop
    );

    // Sequencer side
    modport slave (
        input  run,
        input  pix_valid,
`ifdef MC_SEQ_RD_STALL_EN
        input  rd_stall,
`endif
        output s2p_en,
        output wr_en,
        output wr_addr,
        output rd_en,
        output rd_addr,
        output calc_en,
        output pass_done,
        output err_drop
    );

endinterface : mc_window_sequencer_if
`default_nettype wire

// File: rtl/mc_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_window_sequencer
// Description : Motion-compensation search-window controller. Fills a
//               WIN*WIN circular window SRAM from the s2p stage, then scans
//               a BLK*BLK sub-window (offset OFS) for the calc stage. After
//               the first pass each pass refills UPD pixels and moves the
//               read origin to the oldest entry, wrapping modulo WIN*WIN.
//               Optional feature macro: MC_SEQ_RD_STALL_EN (adds rd_stall,
//               which freezes the scan while asserted in READ).
// Revision    : 1.0  initial release
// ============================================================================
module mc_window_sequencer #(
    parameter int WIN    = 5,
    parameter int BLK    = 3,
    parameter int OFS    = 1,
    parameter int UPD    = 5,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mc_window_sequencer_if.slave  sif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_DEPTH    = WIN * WIN;
    localparam int                c_RC_W     = (BLK > 1) ? $clog2(BLK) : 1;
    localparam logic [ADDR_W-1:0] c_LAST_PTR = ADDR_W'(c_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_LAST_UPD = ADDR_W'(UPD - 1);
    localparam logic [c_RC_W-1:0] c_LAST_RC  = c_RC_W'(BLK - 1);
    localparam logic [ADDR_W:0]   c_DEPTH_X  = (ADDR_W + 1)'(c_DEPTH);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FILL   = 3'd1;
    localparam logic [2:0] c_ST_READ   = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_STREAM = 3'd4;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_origin;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic [c_RC_W-1:0] r_row;
    logic [c_RC_W-1:0] r_col;
    logic              r_calc_en;
    logic              r_pass_done;
    logic              r_err_drop;

    logic              w_stall;
    logic              w_s2p_en;
    logic              w_rd_active;
    logic              w_rd_en;
    logic              w_pix_acc;
    logic              w_last_pix;
    logic              w_scan_last;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_ofs;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_rd_addr;

`ifdef MC_SEQ_RD_STALL_EN
    assign w_stall = sif.rd_stall;
`else
    assign w_stall = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Shared conditions
    // ------------------------------------------------------------------------
    // A pixel is only taken while the s2p stage is enabled.
    assign w_pix_acc = sif.pix_valid & w_s2p_en;

    // Last pixel of the current fill (whole window) or refill (UPD pixels).
    assign w_last_pix = w_pix_acc &
                        (((r_state == c_ST_FILL)   && (r_pix_cnt == c_LAST_PTR)) ||
                         ((r_state == c_ST_STREAM) && (r_pix_cnt == c_LAST_UPD)));

    // Final raster position of the sub-window is being issued this cycle.
    assign w_scan_last = w_rd_en && (r_row == c_LAST_RC) && (r_col == c_LAST_RC);

    // Circular write pointer successor.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : (r_wr_ptr + ADDR_W'(1));

    // ------------------------------------------------------------------------
    // Read address: origin plus in-window offset, one conditional wrap.
    // Both operands are below DEPTH, so a single subtract suffices.
    // ------------------------------------------------------------------------
    assign w_ofs = (ADDR_W + 1)'((OFS + int'(r_row)) * WIN + OFS + int'(r_col));
    assign w_sum = {1'b0, r_origin} + w_ofs;
    assign w_rd_addr = (w_sum >= c_DEPTH_X) ? ADDR_W'(w_sum - c_DEPTH_X)
                                            : ADDR_W'(w_sum);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; run is only consulted when a pass may (re)start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (sif.run) begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                if (w_last_pix) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                if (w_scan_last) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                w_state_nxt = sif.run ? c_ST_STREAM : c_ST_IDLE;
            end
            c_ST_STREAM: begin
                if (w_last_pix) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State-decoded strobes.
    always_comb begin
        w_s2p_en    = 1'b0;
        w_rd_active = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            c_ST_FILL,
            c_ST_STREAM: begin
                w_s2p_en = 1'b1;
            end
            c_ST_READ: begin
                w_rd_active = 1'b1;
                w_rd_en     = ~w_stall;
            end
            default: begin
                w_s2p_en    = 1'b0;
                w_rd_active = 1'b0;
                w_rd_en     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Write side: pointer, per-pass pixel count and next read origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_origin  <= '0;
            r_pix_cnt <= '0;
        end else begin
            if (r_state == c_ST_IDLE) begin
                r_pix_cnt <= '0;
            end
            if (w_pix_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
                if (w_last_pix) begin
                    r_pix_cnt <= '0;
                    // Oldest entry of the window is where the next write lands.
                    r_origin  <= w_wr_ptr_nxt;
                end else begin
                    r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
                end
            end
        end
    end

    // Raster scan counters; they hold during a stall and wrap to 0 at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_rd_en) begin
            if (r_col == c_LAST_RC) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST_RC) ? '0 : (r_row + c_RC_W'(1));
            end else begin
                r_col <= r_col + c_RC_W'(1);
            end
        end
    end

    // Status: calc alignment, end-of-pass pulse and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_calc_en   <= 1'b0;
            r_pass_done <= 1'b0;
            r_err_drop  <= 1'b0;
        end else begin
            r_calc_en   <= w_rd_en;
            r_pass_done <= (r_state == c_ST_DRAIN);
            if (sif.pix_valid && !w_s2p_en) begin
                r_err_drop <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sif.s2p_en    = w_s2p_en;
    assign sif.wr_en     = w_pix_acc;
    assign sif.wr_addr   = r_wr_ptr;
    assign sif.rd_en     = w_rd_en;
    assign sif.rd_addr   = w_rd_active ? w_rd_addr : '0;
    assign sif.calc_en   = r_calc_en;
    assign sif.pass_done = r_pass_done;
    assign sif.err_drop  = r_err_drop;

endmodule : mc_window_sequencer
`default_nettype wire

// File: tb/tb_mc_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_window_sequencer
// Description : Self-checking bench for mc_window_sequencer. Random pixel
//               gaps; expected addresses come from a pixel-count model of
//               the circular window (address = pixel index mod WIN*WIN).
//               Honours MC_SEQ_RD_STALL_EN when defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mc_window_sequencer;

    localparam int WIN    = 5;
    localparam int BLK    = 3;
    localparam int OFS    = 1;
    localparam int UPD    = 5;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = WIN * WIN;
    localparam int NRD    = BLK * BLK;
`ifdef MC_SEQ_RD_STALL_EN
    localparam int STALL_K = 2;
`else
    localparam int STALL_K = -1;
`endif

    logic clk;
    logic rst;

    int vectors = 0;
    int errs    = 0;
    int wcount  = 0;   // total pixels accepted since reset

    mc_window_sequencer_if #(.ADDR_W(ADDR_W)) sif ();

    mc_window_sequencer #(
        .WIN    (WIN),
        .BLK    (BLK),
        .OFS    (OFS),
        .UPD    (UPD),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read address of the k-th raster read given the window origin.
    function automatic int exp_rd(input int origin, input int k);
        return (origin + (OFS + k / BLK) * WIN + OFS + (k % BLK)) % DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s2p_en"},    32'(sif.s2p_en),    0);
        chk({tag, "_wr_en"},     32'(sif.wr_en),     0);
        chk({tag, "_wr_addr"},   32'(sif.wr_addr),   0);
        chk({tag, "_rd_en"},     32'(sif.rd_en),     0);
        chk({tag, "_rd_addr"},   32'(sif.rd_addr),   0);
        chk({tag, "_calc_en"},   32'(sif.calc_en),   0);
        chk({tag, "_pass_done"}, 32'(sif.pass_done), 0);
        chk({tag, "_err_drop"},  32'(sif.err_drop),  0);
    endtask

    // Offer n pixels with random gaps; called at a negedge with s2p enabled.
    task automatic accept(input int n);
        int acc   = 0;
        int guard = 0;
        bit pv;
        while (acc < n && guard < 40 * n) begin
            chk("s2p_en_accept", 32'(sif.s2p_en), 1);
            pv = ($urandom_range(3) != 0);
            sif.pix_valid = pv;
            #1;
            chk("wr_en", 32'(sif.wr_en), 32'(pv));
            if (pv) begin
                chk("wr_addr", 32'(sif.wr_addr), 32'(wcount % DEPTH));
                wcount++;
                acc++;
            end
            guard++;
            @(negedge clk);
        end
        chk("accept_done", 32'(acc), 32'(n));
    endtask

    // Check one READ/DRAIN pass; optional stall, held pix_valid or mid-read reset.
    task automatic read_pass(input int stall_k, input int stall_len,
                             input bit hold_pv, input int rst_k);
        int   origin;
        int   k       = 0;
        int   stalled = 0;
        int   n_rd    = 0;
        int   n_calc  = 0;
        bit   st;
        logic prev_rd = 1'b0;
        origin = wcount % DEPTH;
        sif.pix_valid = hold_pv;
        while (k < NRD) begin
            st = (k == stall_k) && (stalled < stall_len);
`ifdef MC_SEQ_RD_STALL_EN
            sif.rd_stall = st;
`endif
            if (k == rst_k) begin
                sif.pix_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                check_zero("rst_mid_read");
                rst = 1'b0;
                wcount = 0;
                return;
            end
            #1;
            chk("rd_en",      32'(sif.rd_en),   32'(!st));
            chk("rd_addr",    32'(sif.rd_addr), 32'(exp_rd(origin, k)));
            chk("calc_en",    32'(sif.calc_en), 32'(prev_rd));
            chk("wr_en_read", 32'(sif.wr_en),   0);
            n_rd   += int'(sif.rd_en);
            n_calc += int'(sif.calc_en);
            prev_rd = !st;
            if (st) stalled++;
            else    k++;
            @(negedge clk);
        end
`ifdef MC_SEQ_RD_STALL_EN
        sif.rd_stall = 1'b0;
`endif
        sif.pix_valid = 1'b0;
        chk("drain_rd_en",     32'(sif.rd_en),     0);
        chk("drain_calc_en",   32'(sif.calc_en),   1);
        chk("drain_pass_done", 32'(sif.pass_done), 0);
        n_calc += int'(sif.calc_en);
        @(negedge clk);
        chk("pass_done",      32'(sif.pass_done), 1);
        chk("post_calc_en",   32'(sif.calc_en),   0);
        chk("rd_en_total",    32'(n_rd),          32'(NRD));
        chk("calc_en_total",  32'(n_calc),        32'(NRD));
    endtask

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, errs);
        $fatal(1, "watchdog expired");
    end

    // Directed sequence with randomized pixel timing.
    initial begin
        rst           = 1'b1;
        sif.run       = 1'b0;
        sif.pix_valid = 1'b0;
`ifdef MC_SEQ_RD_STALL_EN
        sif.rd_stall  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Initial fill, first scan (origin 0)
        rst     = 1'b0;
        sif.run = 1'b1;
        @(negedge clk);
        accept(DEPTH);
        read_pass(STALL_K, 2, 1'b0, -1);

        // First refill, origin 5
        accept(UPD);
        read_pass(-1, 0, 1'b0, -1);
        chk("err_drop_clean", 32'(sif.err_drop), 0);

        // Second refill, origin 10 (read wraps); pix_valid held during READ
        accept(UPD);
        read_pass(-1, 0, 1'b1, -1);
        chk("err_drop_set", 32'(sif.err_drop), 1);

        // run dropped mid-refill: pass completes, then idle
        sif.run = 1'b0;
        accept(UPD);
        read_pass(-1, 0, 1'b0, -1);
        repeat (3) begin
            chk("idle_s2p_en",      32'(sif.s2p_en),   0);
            chk("err_drop_sticky",  32'(sif.err_drop), 1);
            @(negedge clk);
        end

        // Restart from idle, then reset on the 4th read cycle
        sif.run = 1'b1;
        @(negedge clk);
        accept(DEPTH);
        read_pass(-1, 0, 1'b0, 3);

        // Recovery: fill restarts at address 0
        @(negedge clk);
        accept(DEPTH);
        read_pass(-1, 0, 1'b0, -1);
        chk("err_drop_after_rst", 32'(sif.err_drop), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_mc_window_sequencer
`default_nettype wire
